audio_stream_serializer: RTL

AUDIO_STREAM_SERIALIZER -- requirements
Module: audio_stream_serializer

---
 rtl/audio_stream_serializer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/audio_stream_serializer.sv
// audio_stream_serializer
// Buffers audio sample words in a small FIFO and shifts them out one bit per
// programmable bit period, MSB or LSB first, on an open-drain pin.
// Optional build macro: AUDIO_SER_UNDERFLOW_CNT_EN adds a 16-bit saturating
// UNDERFLOW_CNT output that counts underflow events.
module audio_stream_serializer #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                        HCLK,
   input  logic                        HRESETn,
   input  logic                        EN,
   input  logic [DIV_WIDTH-1:0]        CLK_DIV,
   input  logic                        MSB_FIRST,
   input  logic [DATA_WIDTH-1:0]       S_DATA,
   input  logic                        S_VALID,
   output logic                        S_READY,
   input  logic                        CLR_UNDERFLOW,
   output logic                        UNDERFLOW,
`ifdef AUDIO_SER_UNDERFLOW_CNT_EN
   output logic [15:0]                 UNDERFLOW_CNT,
`endif
   output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
   output logic                        DONE,
   output logic                        SER_BIT,
   inout  wire                         PWM_AUDIO
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(DATA_WIDTH);

   localparam logic [LW-1:0]         DEPTH_L  = LW'(FIFO_DEPTH);
   localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // Divider and shifter state
   logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
   logic [DIV_WIDTH-1:0]  div_lim_q, div_lim_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q,   shift_d;
   logic                  msb_q,     msb_d;
   logic                  done_q,    done_d;
   logic                  underflow_q, underflow_d;

   // FIFO state
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q,  level_d;

   // Per-cycle events
   logic tick;      // last HCLK cycle of a bit period
   logic load;      // tick that starts a new word
   logic push;
   logic pop;
   logic uf_event;  // word slot started with nothing to send

   assign tick     = EN && (div_cnt_q == div_lim_q);
   assign load     = tick && (bit_cnt_q == '0);
   assign S_READY  = (level_q < DEPTH_L);
   assign push     = S_VALID && S_READY;
   assign pop      = load && (level_q != '0);
   assign uf_event = load && (level_q == '0);

   // Bit timing, word loading and shifting.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
      div_cnt_d = div_cnt_q;
      div_lim_d = div_lim_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      msb_d     = msb_q;
      done_d    = 1'b0;
      if (!EN) begin
         // Idle: keep tracking CLK_DIV so the first period after enable uses it.
         div_cnt_d = '0;
         div_lim_d = CLK_DIV;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (tick) begin
         div_cnt_d = '0;
         div_lim_d = CLK_DIV;
         done_d    = (bit_cnt_q == LAST_BIT);
         bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
         if (load) begin
            msb_d   = MSB_FIRST;
            shift_d = pop ? mem_q[rd_ptr_q] : MIDSCALE;
         end else if (msb_q) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
         end else begin
            shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
         end
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   // FIFO pointer and occupancy update; pointers wrap naturally (power-of-2 depth).
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Sticky underflow flag; a fresh event wins over a clear.
   always_comb begin
      underflow_d = underflow_q;
      if (uf_event) begin
         underflow_d = 1'b1;
      end else if (CLR_UNDERFLOW) begin
         underflow_d = 1'b0;
      end
   end

   // Control state registers with asynchronous reset.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
         div_cnt_q   <= '0;
         div_lim_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         msb_q       <= 1'b1;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         div_lim_q   <= div_lim_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         msb_q       <= msb_d;
         done_q      <= done_d;
         underflow_q <= underflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge HCLK) begin
      // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
      if (push) begin
         mem_q[wr_ptr_q] <= S_DATA;
      end
   end

`ifdef AUDIO_SER_UNDERFLOW_CNT_EN
   logic [15:0] uf_cnt_q, uf_cnt_d;

   // Saturating underflow event counter; a clear coinciding with an event leaves 1.
   always_comb begin
      uf_cnt_d = uf_cnt_q;
      if (CLR_UNDERFLOW) begin
         uf_cnt_d = uf_event ? 16'd1 : 16'd0;
      end else if (uf_event && (uf_cnt_q != 16'hFFFF)) begin
         uf_cnt_d = uf_cnt_q + 16'd1;
      end
   end

   // Underflow counter register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         uf_cnt_q <= '0;
      end else begin
         uf_cnt_q <= uf_cnt_d;
      end
   end

   assign UNDERFLOW_CNT = uf_cnt_q;
`endif

   assign FIFO_LEVEL = level_q;
   assign UNDERFLOW  = underflow_q;
   assign DONE       = done_q;
   // The bit order is fixed per word, so the output tap follows the latched order.
   assign SER_BIT    = msb_q ? shift_q[DATA_WIDTH-1] : shift_q[0];
   assign PWM_AUDIO  = SER_BIT ? 1'bz : 1'b0;

endmodule
